// File: rtl/mux_pkg.sv
// Shared constants and helpers for the bit-select multiplexer.
// Consumers import mux_pkg::*.
package mux_pkg;

  localparam int MUX_DEFAULT_INPUTS = 4;

  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_1_core.sv
// Pure combinational N:1 bit selector.
// Out-of-range select yields 0.
module mux_1_core
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = MUX_DEFAULT_INPUTS,
  parameter int SEL_W      = sel_width(NUM_INPUTS)
) (
  input  logic [SEL_W-1:0]      select,
  input  logic [NUM_INPUTS-1:0] d,
  output logic                  q
);

  always_comb begin
    q = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (select == SEL_W'(i)) q = d[i];
    end
  end

endmodule

// File: rtl/mux_1.sv
// N:1 bit-select mux with registered copy of the output.
// Define MUX_1_SEL_CHECK_EN to add the registered sel_err flag.
module mux_1
  import mux_pkg::*;
#(
  parameter  int NUM_INPUTS = MUX_DEFAULT_INPUTS,
  localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      select,
  input  logic [NUM_INPUTS-1:0] d,
  output logic                  q,
  output logic                  q_q
`ifdef MUX_1_SEL_CHECK_EN
  ,
  output logic                  sel_err
`endif
);

  mux_1_core #(
    .NUM_INPUTS(NUM_INPUTS),
    .SEL_W     (SEL_W)
  ) u_core (
    .select(select),
    .d     (d),
    .q     (q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q;
  end

`ifdef MUX_1_SEL_CHECK_EN
  // Extra bit so NUM_INPUTS itself is representable.
  logic oor;
  assign oor = {1'b0, select} >= (SEL_W+1)'(NUM_INPUTS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= oor;
  end
`endif

endmodule

// File: tb/tb_mux_1.sv
// Self-checking bench for mux_1 (4-input and 3-input instances).
// Builds with or without MUX_1_SEL_CHECK_EN.
module tb_mux_1;

  logic       clk;
  logic       rst_n;
  logic [1:0] select;
  logic [3:0] d;
  logic       q, q_q;
  logic [1:0] select3;
  logic [2:0] d3;
  logic       q3, q_q3;
`ifdef MUX_1_SEL_CHECK_EN
  logic       sel_err, sel_err3;
`endif

  int tests  = 0;
  int failed = 0;

  mux_1 #(.NUM_INPUTS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .select(select),
    .d     (d),
    .q     (q),
    .q_q   (q_q)
`ifdef MUX_1_SEL_CHECK_EN
    ,
    .sel_err(sel_err)
`endif
  );

  mux_1 #(.NUM_INPUTS(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .select(select3),
    .d     (d3),
    .q     (q3),
    .q_q   (q_q3)
`ifdef MUX_1_SEL_CHECK_EN
    ,
    .sel_err(sel_err3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_q(input int n, input int dv, input int s);
    if (s >= n) return 1'b0;
    return ((dv >> s) & 1) != 0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic exp_prev, exp_prev3, flip;

  initial begin
    rst_n   = 1'b0;
    d       = 4'hF;
    select  = 2'd0;
    d3      = 3'b000;
    select3 = 2'd0;
    #1;
    check("reset_q_q", q_q, 1'b0);
    check("reset_q", q, 1'b1);
    check("reset_q_q3", q_q3, 1'b0);
`ifdef MUX_1_SEL_CHECK_EN
    check("reset_sel_err", sel_err, 1'b0);
`endif

    for (int dv = 0; dv < 16; dv++) begin
      for (int s = 0; s < 4; s++) begin
        d      = 4'(dv);
        select = 2'(s);
        #1;
        check($sformatf("exh_d%0d_s%0d", dv, s), q, ref_q(4, dv, s));
      end
    end

    d      = 4'b1000;
    select = 2'd3;
    #1;
    check("same_step_a", q, 1'b1);
    d = 4'b0111;
    #0;
    check("same_step_b", q, 1'b0);

    @(negedge clk);
    d      = 4'hF;
    select = 2'd0;
    #1;
    check("in_reset_q_q", q_q, 1'b0);
    check("in_reset_q", q, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_q_q", q_q, 1'b1);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_q_q", q_q, 1'b0);
    check("async_rst_q", q, 1'b1);
    #1;
    rst_n = 1'b1;

    d    = 4'b0101;
    flip = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      select   = flip ? 2'd1 : 2'd0;
      flip     = ~flip;
      exp_prev = ref_q(4, int'(d), int'(select));
      @(posedge clk);
      #1;
      check($sformatf("toggle_%0d", i), q_q, exp_prev);
    end

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d         = 4'($urandom);
      select    = 2'($urandom);
      d3        = 3'($urandom);
      select3   = 2'($urandom);
      #1;
      check($sformatf("rnd_q_%0d", i), q, ref_q(4, int'(d), int'(select)));
      check($sformatf("rnd_q3_%0d", i), q3,
            ref_q(3, int'(d3), int'(select3)));
      exp_prev  = ref_q(4, int'(d), int'(select));
      exp_prev3 = ref_q(3, int'(d3), int'(select3));
      @(posedge clk);
      #1;
      check($sformatf("rnd_q_q_%0d", i), q_q, exp_prev);
      check($sformatf("rnd_q_q3_%0d", i), q_q3, exp_prev3);
`ifdef MUX_1_SEL_CHECK_EN
      check($sformatf("rnd_err3_%0d", i), sel_err3, int'(select3) >= 3);
      check($sformatf("rnd_err_%0d", i), sel_err, 1'b0);
`endif
    end

    @(negedge clk);
    d3      = 3'b111;
    select3 = 2'd3;
    #1;
    check("oor_q3", q3, 1'b0);
    @(posedge clk);
    #1;
    check("oor_q_q3", q_q3, 1'b0);
`ifdef MUX_1_SEL_CHECK_EN
    check("oor_sel_err_set", sel_err3, 1'b1);
`endif
    @(negedge clk);
    select3 = 2'd2;
    #1;
    check("inrange_q3", q3, 1'b1);
    @(posedge clk);
    #1;
    check("inrange_q_q3", q_q3, 1'b1);
`ifdef MUX_1_SEL_CHECK_EN
    check("oor_sel_err_clr", sel_err3, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
